// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter, round-robin,
// a single transaction in flight from grant to response.
module axi4_lite_arbiter_2to1 #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [1:0][addr_width_p-1:0]         m_awaddr_i,
  input  logic [1:0][2:0]                      m_awprot_i,
  input  logic [1:0]                           m_awvalid_i,
  output logic [1:0]                           m_awready_o,
  input  logic [1:0][data_width_p-1:0]         m_wdata_i,
  input  logic [1:0][data_width_p/8-1:0]       m_wstrb_i,
  input  logic [1:0]                           m_wvalid_i,
  output logic [1:0]                           m_wready_o,
  output logic [1:0][1:0]                      m_bresp_o,
  output logic [1:0]                           m_bvalid_o,
  input  logic [1:0]                           m_bready_i,
  input  logic [1:0][addr_width_p-1:0]         m_araddr_i,
  input  logic [1:0][2:0]                      m_arprot_i,
  input  logic [1:0]                           m_arvalid_i,
  output logic [1:0]                           m_arready_o,
  output logic [1:0][data_width_p-1:0]         m_rdata_o,
  output logic [1:0][1:0]                      m_rresp_o,
  output logic [1:0]                           m_rvalid_o,
  input  logic [1:0]                           m_rready_i,
  output logic [addr_width_p-1:0]              s_awaddr_o,
  output logic [2:0]                           s_awprot_o,
  output logic                                 s_awvalid_o,
  input  logic                                 s_awready_i,
  output logic [data_width_p-1:0]              s_wdata_o,
  output logic [data_width_p/8-1:0]            s_wstrb_o,
  output logic                                 s_wvalid_o,
  input  logic                                 s_wready_i,
  input  logic [1:0]                           s_bresp_i,
  input  logic                                 s_bvalid_i,
  output logic                                 s_bready_o,
  output logic [addr_width_p-1:0]              s_araddr_o,
  output logic [2:0]                           s_arprot_o,
  output logic                                 s_arvalid_o,
  input  logic                                 s_arready_i,
  input  logic [data_width_p-1:0]              s_rdata_i,
  input  logic [1:0]                           s_rresp_i,
  input  logic                                 s_rvalid_i,
  output logic                                 s_rready_o,
  output logic [1:0]                           grant_o,
  output logic                                 busy_o
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  state_t     state;
  logic       g;
  logic       rr;
  logic       aw_done;
  logic       w_done;
  logic [1:0] req;
  logic       pick;
  logic       in_wr, in_wresp, in_rda, in_rdd;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req  = m_awvalid_i | m_arvalid_i;
  assign pick = (&req) ? rr : req[1];

  assign in_wr    = (state == WR);
  assign in_wresp = (state == WR_RESP);
  assign in_rda   = (state == RD_ADDR);
  assign in_rdd   = (state == RD_DATA);

  // Payload muxes depend only on the registered grant index.
  assign s_awaddr_o = busy_o ? m_awaddr_i[g] : '0;
  assign s_awprot_o = busy_o ? m_awprot_i[g] : '0;
  assign s_wdata_o  = busy_o ? m_wdata_i[g]  : '0;
  assign s_wstrb_o  = busy_o ? m_wstrb_i[g]  : '0;
  assign s_araddr_o = busy_o ? m_araddr_i[g] : '0;
  assign s_arprot_o = busy_o ? m_arprot_i[g] : '0;

  assign s_awvalid_o = in_wr & m_awvalid_i[g] & ~aw_done;
  assign s_wvalid_o  = in_wr & m_wvalid_i[g] & ~w_done;
  assign s_bready_o  = in_wresp & m_bready_i[g];
  assign s_arvalid_o = in_rda & m_arvalid_i[g];
  assign s_rready_o  = in_rdd & m_rready_i[g];

  assign aw_hs = s_awvalid_o & s_awready_i;
  assign w_hs  = s_wvalid_o & s_wready_i;
  assign b_hs  = s_bready_o & s_bvalid_i;
  assign ar_hs = s_arvalid_o & s_arready_i;
  assign r_hs  = s_rready_o & s_rvalid_i;

  always_comb begin
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bvalid_o  = '0;
    m_bresp_o   = '0;
    m_arready_o = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = '0;
    m_rresp_o   = '0;
    m_awready_o[g] = in_wr & ~aw_done & s_awready_i;
    m_wready_o[g]  = in_wr & ~w_done & s_wready_i;
    m_bvalid_o[g]  = in_wresp & s_bvalid_i;
    m_bresp_o[g]   = busy_o ? s_bresp_i : 2'b00;
    m_arready_o[g] = in_rda & s_arready_i;
    m_rvalid_o[g]  = in_rdd & s_rvalid_i;
    m_rdata_o[g]   = busy_o ? s_rdata_i : '0;
    m_rresp_o[g]   = busy_o ? s_rresp_i : 2'b00;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      g       <= 1'b0;
      rr      <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      grant_o <= 2'b00;
      busy_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            g       <= pick;
            grant_o <= pick ? 2'b10 : 2'b01;
            busy_o  <= 1'b1;
            state   <= m_awvalid_i[pick] ? WR : RD_ADDR;
          end
        end
        WR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            busy_o  <= 1'b0;
            rr      <= ~g;
          end
        end
        RD_ADDR: begin
          if (ar_hs) state <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            busy_o  <= 1'b0;
            rr      <= ~g;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Bench for axi4_lite_arbiter_2to1: directed scenarios, then
// random masters and slave against a memory/round-robin model.
module tb_axi4_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][27:0] m_awaddr, m_araddr;
  logic [1:0][2:0]  m_awprot, m_arprot;
  logic [1:0]       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [1:0][63:0] m_wdata;
  logic [1:0][7:0]  m_wstrb;
  logic [1:0]       m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0][1:0]  m_bresp, m_rresp;
  logic [1:0][63:0] m_rdata;
  logic [27:0]      s_awaddr, s_araddr;
  logic [2:0]       s_awprot, s_arprot;
  logic             s_awvalid, s_awready, s_wvalid, s_wready;
  logic             s_bvalid, s_bready, s_arvalid, s_arready;
  logic             s_rvalid, s_rready;
  logic [63:0]      s_wdata, s_rdata;
  logic [7:0]       s_wstrb;
  logic [1:0]       s_bresp, s_rresp;
  logic [1:0]       grant;
  logic             busy;

  axi4_lite_arbiter_2to1 dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .m_awaddr_i(m_awaddr), .m_awprot_i(m_awprot),
    .m_awvalid_i(m_awvalid), .m_awready_o(m_awready),
    .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_wvalid_i(m_wvalid), .m_wready_o(m_wready),
    .m_bresp_o(m_bresp), .m_bvalid_o(m_bvalid), .m_bready_i(m_bready),
    .m_araddr_i(m_araddr), .m_arprot_i(m_arprot),
    .m_arvalid_i(m_arvalid), .m_arready_o(m_arready),
    .m_rdata_o(m_rdata), .m_rresp_o(m_rresp),
    .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
    .s_awaddr_o(s_awaddr), .s_awprot_o(s_awprot),
    .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
    .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
    .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready),
    .s_araddr_o(s_araddr), .s_arprot_o(s_arprot),
    .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
    .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .grant_o(grant), .busy_o(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_aw = 0;
  int n_w = 0;
  int a0, w0;
  bit done;
  logic [63:0] smem [logic [27:0]];
  logic [63:0] ref_mem [logic [27:0]];

  always @(posedge clk) begin
    if (s_awvalid && s_awready) n_aw <= n_aw + 1;
    if (s_wvalid && s_wready) n_w <= n_w + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] init_val(input logic [27:0] a);
    return {a, 8'h5A, a};
  endfunction

  function automatic logic [1:0] resp_of(input logic [27:0] a);
    return a[3] ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old,
    input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic clear_inputs();
    m_awaddr = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    m_arvalid = '0; m_rready = '0; m_wdata = '0; m_wstrb = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
  endtask

  task automatic master_run(input int id, input int n);
    logic [27:0] a;
    logic [63:0] d, exp;
    logic [7:0]  s;
    int t, d1, d2;
    bit ok1, ok2, ok3;
    for (int k = 0; k < n; k++) begin
      a = {20'h0, id[0], 4'($urandom_range(0, 15)), 3'b000};
      d = {$urandom, $urandom};
      s = 8'($urandom_range(1, 255));
      d1 = $urandom_range(0, 3);
      d2 = $urandom_range(0, 3);
      t = 0; ok1 = 0; ok2 = 0; ok3 = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        m_awaddr[id] = a; m_awprot[id] = 3'(id);
        m_wdata[id] = d; m_wstrb[id] = s;
        while (!ok3 && t < 500) begin
          @(negedge clk);
          m_awvalid[id] = !ok1 && t >= d1;
          m_wvalid[id] = !ok2 && t >= d2;
          m_bready[id] = ($urandom_range(0, 3) != 0);
          #1;
          if (m_awvalid[id] && m_awready[id]) ok1 = 1;
          if (m_wvalid[id] && m_wready[id]) ok2 = 1;
          if (m_bvalid[id] && m_bready[id]) begin
            ok3 = 1;
            chk("bresp", 64'(m_bresp[id]), 64'(resp_of(a)));
            exp = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            ref_mem[a] = merge(exp, d, s);
          end
          t++;
        end
      end else begin
        m_araddr[id] = a; m_arprot[id] = 3'(id);
        while (!ok3 && t < 500) begin
          @(negedge clk);
          m_arvalid[id] = !ok1 && t >= d1;
          m_rready[id] = ($urandom_range(0, 3) != 0);
          #1;
          if (m_arvalid[id] && m_arready[id]) ok1 = 1;
          if (m_rvalid[id] && m_rready[id]) begin
            ok3 = 1;
            exp = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            chk("rdata", m_rdata[id], exp);
            chk("rresp", 64'(m_rresp[id]), 64'(resp_of(a)));
          end
          t++;
        end
      end
      if (!ok3) chk("timeout", 64'(t), 64'(0));
      @(negedge clk);
      m_awvalid[id] = 0; m_wvalid[id] = 0; m_arvalid[id] = 0;
      m_bready[id] = 0; m_rready[id] = 0;
    end
  endtask

  task automatic slave_run();
    bit ga, gw, bp, rp;
    logic [27:0] wa;
    logic [63:0] wd;
    logic [7:0]  ws;
    ga = 0; gw = 0; bp = 0; rp = 0;
    while (!done) begin
      @(negedge clk);
      s_awready = 1'($urandom_range(0, 1));
      s_wready  = 1'($urandom_range(0, 1));
      s_arready = 1'($urandom_range(0, 1));
      s_bvalid  = bp && (s_bvalid || $urandom_range(0, 2) == 0);
      s_rvalid  = rp && (s_rvalid || $urandom_range(0, 2) == 0);
      #1;
      if (s_bvalid && s_bready) bp = 0;
      if (s_rvalid && s_rready) rp = 0;
      if (s_awvalid && s_awready) begin ga = 1; wa = s_awaddr; end
      if (s_wvalid && s_wready) begin
        gw = 1; wd = s_wdata; ws = s_wstrb;
      end
      if (ga && gw) begin
        smem[wa] = merge(smem.exists(wa) ? smem[wa] : init_val(wa), wd, ws);
        s_bresp = resp_of(wa);
        bp = 1; ga = 0; gw = 0;
      end
      if (s_arvalid && s_arready) begin
        s_rdata = smem.exists(s_araddr) ? smem[s_araddr] : init_val(s_araddr);
        s_rresp = resp_of(s_araddr);
        rp = 1;
      end
    end
  endtask

  task automatic monitor_run();
    logic [1:0] pg, pr, pa;
    int pref, e;
    pg = 0; pr = 0; pa = 0; pref = 0;
    while (!done) begin
      @(negedge clk);
      #2;
      if (grant != 0 && pg == 0) begin
        e = (pr == 2'b11) ? pref : (pr[1] ? 1 : 0);
        chk("rr_grant", 64'(grant), 64'(2'b01 << e));
        chk("op_sel", {s_awvalid, s_arvalid}, pa[e] ? 2'b10 : 2'b01);
        pref = 1 - e;
      end
      chk("excl", 64'(s_awvalid & s_arvalid), 0);
      chk("busy", 64'(busy), 64'(|grant));
      for (int i = 0; i < 2; i++)
        if (!grant[i])
          chk("ungranted", {m_awready[i], m_wready[i], m_bvalid[i],
                            m_arready[i], m_rvalid[i]}, 0);
      pg = grant; pr = m_awvalid | m_arvalid; pa = m_awvalid;
    end
  endtask

  initial begin
    rst_n = 0;
    done = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_s", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
    chk("rst_m", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
    chk("rst_addr", {s_awaddr, s_araddr}, 0);
    @(negedge clk); rst_n = 1;

    // both masters read together right after reset
    @(negedge clk);
    m_arvalid = 2'b11; m_araddr[0] = 28'h100; m_araddr[1] = 28'h200;
    m_rready = 2'b11; s_arready = 1;
    #1 chk("t3_lat", 64'(grant), 0);
    @(negedge clk); #1;
    chk("t3_g0", 64'(grant), 2'b01);
    chk("t3_ar0", 64'(s_araddr), 28'h100);
    chk("t3_rdy", 64'(m_arready), 2'b01);
    @(negedge clk); m_arvalid[0] = 0; s_rvalid = 1; s_rdata = 64'h1111;
    #1 chk("t3_rv0", 64'(m_rvalid), 2'b01);
    chk("t3_rd0", m_rdata[0], 64'h1111);
    @(negedge clk); s_rvalid = 0;
    #1 chk("t3_idle", 64'(grant), 0);
    chk("t3_m1wait", {m_arready[1], m_rvalid[1]}, 0);
    @(negedge clk); #1;
    chk("t3_g1", 64'(grant), 2'b10);
    chk("t3_ar1", 64'(s_araddr), 28'h200);
    @(negedge clk); m_arvalid[1] = 0; s_rvalid = 1; s_rdata = 64'h2222;
    #1 chk("t3_rv1", 64'(m_rvalid), 2'b10);
    chk("t3_rd1", m_rdata[1], 64'h2222);
    @(negedge clk); clear_inputs();

    // single write from m0
    @(negedge clk);
    m_awvalid[0] = 1; m_awaddr[0] = 28'h40; m_wvalid[0] = 1;
    m_wdata[0] = 64'hDEADBEEF_01234567; m_wstrb[0] = 8'hFF;
    m_bready[0] = 1; s_awready = 1; s_wready = 1;
    #1 chk("t1_lat", {s_awvalid, s_wvalid}, 0);
    @(negedge clk); #1;
    chk("t1_grant", 64'(grant), 2'b01);
    chk("t1_fwd", {s_awvalid, s_wvalid}, 2'b11);
    chk("t1_addr", 64'(s_awaddr), 28'h40);
    chk("t1_data", s_wdata, 64'hDEADBEEF_01234567);
    chk("t1_strb", 64'(s_wstrb), 8'hFF);
    chk("t1_rdy", {m_awready, m_wready}, 4'b0101);
    @(negedge clk); m_awvalid[0] = 0; m_wvalid[0] = 0;
    #1 chk("t1_bwait", 64'(m_bvalid), 0);
    chk("t1_bready", 64'(s_bready), 1);
    @(negedge clk); s_bvalid = 1; s_bresp = 2'b01;
    #1 chk("t1_bvalid", 64'(m_bvalid), 2'b01);
    chk("t1_bresp", 64'(m_bresp[0]), 2'b01);
    @(negedge clk); clear_inputs();
    #1 chk("t1_idle", {busy, grant}, 0);

    // W three cycles ahead of AW, slave W ready late
    @(negedge clk);
    a0 = n_aw; w0 = n_w;
    s_awready = 1; s_wready = 0; m_wvalid[0] = 1; m_wdata[0] = 64'h55;
    m_wstrb[0] = 8'h0F; m_bready[0] = 1; m_awaddr[0] = 28'h48;
    repeat (3) begin
      #1 chk("t2_nogrant", {grant, s_wvalid}, 0);
      @(negedge clk);
    end
    m_awvalid[0] = 1;
    #1 chk("t2_lat", 64'(grant), 0);
    @(negedge clk); #1;
    chk("t2_grant", 64'(grant), 2'b01);
    chk("t2_fwd", {s_awvalid, s_wvalid}, 2'b11);
    @(negedge clk); m_awvalid[0] = 0;
    #1 chk("t2_wwait", {s_awvalid, s_wvalid, s_bready}, 3'b010);
    @(negedge clk); s_wready = 1;
    #1 chk("t2_wfwd", {s_wvalid, s_bready}, 2'b10);
    @(negedge clk); m_wvalid[0] = 0; s_wready = 0; s_bvalid = 1;
    #1 chk("t2_resp", 64'(m_bvalid), 2'b01);
    chk("t2_aw1", 64'(n_aw - a0), 1);
    chk("t2_w1", 64'(n_w - w0), 1);
    @(negedge clk); clear_inputs();
    #1 chk("t2_idle", 64'(grant), 0);

    // m1 raises write and read together
    @(negedge clk);
    m_awvalid[1] = 1; m_arvalid[1] = 1; m_wvalid[1] = 1;
    m_awaddr[1] = 28'h80; m_araddr[1] = 28'h88; m_wdata[1] = 64'h77;
    m_wstrb[1] = 8'hFF; m_bready[1] = 1; m_rready[1] = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    #1 chk("t5_lat", 64'(grant), 0);
    @(negedge clk); #1;
    chk("t5_grant", 64'(grant), 2'b10);
    chk("t5_wrfirst", {s_awvalid, s_arvalid}, 2'b10);
    chk("t5_noar", 64'(m_arready), 0);
    @(negedge clk); m_awvalid[1] = 0; m_wvalid[1] = 0; s_bvalid = 1;
    #1 chk("t5_b", 64'(m_bvalid), 2'b10);
    chk("t5_noar2", 64'(s_arvalid), 0);
    @(negedge clk); s_bvalid = 0;
    #1 chk("t5_idle", {grant, s_arvalid}, 0);
    @(negedge clk); #1;
    chk("t5_rd", {s_awvalid, s_arvalid}, 2'b01);
    chk("t5_g", 64'(grant), 2'b10);
    @(negedge clk); m_arvalid[1] = 0; s_rvalid = 1; s_rdata = 64'h99;
    #1 chk("t5_r", 64'(m_rvalid), 2'b10);
    @(negedge clk); clear_inputs();

    // reset while a read response is pending
    m_arvalid[0] = 1; m_araddr[0] = 28'h300; s_arready = 1;
    @(negedge clk);
    #1 chk("t6_g", 64'(grant), 2'b01);
    @(negedge clk); m_arvalid[0] = 0; s_rvalid = 1; s_rdata = 64'hAB;
    #1 chk("t6_pend", 64'(m_rvalid), 2'b01);
    #1 rst_n = 0;
    #1 chk("t6_rst_out", {m_awready, m_wready, m_bvalid, m_arready,
                          m_rvalid, s_awvalid, s_wvalid, s_bready,
                          s_arvalid, s_rready}, 0);
    chk("t6_rst_g", {busy, grant}, 0);
    @(negedge clk);
    s_rvalid = 0; rst_n = 1;
    m_arvalid[1] = 1; m_araddr[1] = 28'h208; m_rready[1] = 1;
    #1 chk("t6_lat", 64'(grant), 0);
    @(negedge clk); #1;
    chk("t6_g1", 64'(grant), 2'b10);
    chk("t6_ar1", 64'(s_araddr), 28'h208);
    @(negedge clk); m_arvalid[1] = 0; s_rvalid = 1; s_rdata = 64'hCD;
    #1 chk("t6_rv1", 64'(m_rvalid), 2'b10);
    chk("t6_rd1", m_rdata[1], 64'hCD);
    @(negedge clk); clear_inputs();
    #1 chk("t6_idle", 64'(grant), 0);

    fork
      begin
        fork
          master_run(0, 30);
          master_run(1, 30);
        join
        done = 1;
      end
      slave_run();
      monitor_run();
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
